// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter in front of one peripheral bus; 3-cycle minimum per transaction.
// Optional watchdog (macro ARB_TIMEOUT_EN) forces completion with ERR_DATA when the slave never acks.
module periph_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ready,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_we,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        grant_id,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant_id;
  logic        r_s_valid;
  logic        r_s_we;
  logic        r_busy;
  logic [31:0] r_s_addr;
  logic [31:0] r_s_wdata;

  logic w_req;
  logic w_win;
  logic w_done;
  logic w_tmo;
  logic w_fin;

  assign w_req  = m0_valid | m1_valid;
  // On a tie the master that did not win last time goes next.
  assign w_win  = (m0_valid & m1_valid) ? ~r_last_grant : m1_valid;
  assign w_done = (r_state == ST_BUSY) & s_ready;
  assign w_fin  = w_done | w_tmo;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout_flag;

  // s_ready in the same cycle as the limit wins; w_tmo is masked by it.
  assign w_tmo        = (r_state == ST_BUSY) & ~s_ready & (r_cnt == 16'(TIMEOUT_CYCLES));
  assign timeout_flag = r_timeout_flag;
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_tmo            = 1'b0;
  assign timeout_flag     = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_s_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_s_addr     <= 32'd0;
      r_s_wdata    <= 32'd0;
      r_s_we       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt          <= 16'd0;
      r_timeout_flag <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_s_addr     <= w_win ? m1_addr  : m0_addr;
            r_s_wdata    <= w_win ? m1_wdata : m0_wdata;
            r_s_we       <= w_win ? m1_we    : m0_we;
            r_s_valid    <= 1'b1;
            r_busy       <= 1'b1;
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_state      <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt        <= 16'd0;
`endif
          end
        end
        ST_BUSY: begin
          // Dropping s_valid at the ack edge prevents a duplicate slave transaction.
          if (w_fin) begin
            r_s_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          if (w_tmo) begin
            r_timeout_flag <= 1'b1;
          end else if (!s_ready) begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
      endcase
    end
  end

  assign m0_ready = w_fin & ~r_grant_id;
  assign m1_ready = w_fin &  r_grant_id;
  assign m_rdata  = w_tmo ? ERR_DATA : s_rdata;
  assign s_valid  = r_s_valid;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_we     = r_s_we;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Two-master arbiter sharing the single peripheral bus (addr/wdata/we/valid → rdata/ready) between the CPU (master 0) and a second requester such as DMA or debug (master 1).
- Grants one transaction at a time with round-robin priority.
- Registers the winning request onto the slave side and routes the one-cycle ready pulse back to the granted master only.
- Optional watchdog terminates transactions the peripheral never acknowledges.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles before forced completion (1..65535); used only with ARB_TIMEOUT_EN.
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
m0_valid  input  1  master 0 request; held until m0_ready
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_we  input  1  master 0 write enable
m0_ready  output  1  master 0 completion pulse
m1_valid / m1_addr / m1_wdata / m1_we / m1_ready  same as master 0, for master 1
m_rdata  output  32  read data shared by both masters; meaningful only while the matching mX_ready is high
s_valid  output  1  request to peripheral block
s_addr  output  32  registered address
s_wdata  output  32  registered write data
s_we  output  1  registered write enable
s_rdata  input  32  peripheral read data
s_ready  input  1  peripheral one-cycle acknowledge
grant_id  output  1  master currently owning the bus
busy  output  1  high while in BUSY
timeout_flag  output  1  sticky; set on any timeout

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - all outputs are 0, except m_rdata, which follows s_rdata combinationally;
  - state=IDLE; last_grant=1, so master 0 wins the first tie.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any mX_valid is high, select the winner. Single requester wins outright. If both request, the winner is the master ≠ last_grant.
  - At the clock edge: latch the winner's addr/wdata/we into s_addr/s_wdata/s_we; set s_valid=1, grant_id=winner, last_grant=winner, busy=1; go to BUSY.
- BUSY:
  - s_valid stays high; s_addr/s_wdata/s_we stay frozen; master inputs are ignored.
  - When s_ready=1, combinationally: m{grant_id}_ready=1 and m_rdata=s_rdata. The other master's ready stays 0.
  - At that edge: s_valid←0, busy←0, go to IDLE.
- Latency (request seen at edge N):
  - s_valid high in cycle N+1.
  - With the peripheral's one-cycle acknowledge, s_ready and mX_ready are high in cycle N+2.
  - IDLE in cycle N+3.
  - Minimum 3 cycles per transaction.
- Because s_valid is cleared at the same edge the peripheral samples valid&&ready, the peripheral never starts a duplicate transaction.
- Master rule: mX_valid must drop, or carry a new request, in the cycle after mX_ready.
- A request arriving during BUSY is held off and is arbitrated in the next IDLE cycle. No request is lost while valid is held.
- s_ready while in IDLE is ignored: no mX_ready is generated.
- Reset asserted mid-transaction aborts it immediately. Neither master receives ready; s_valid drops asynchronously.
- grant_id holds its last value in IDLE.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES with s_ready still 0, that cycle: m{grant_id}_ready=1, m_rdata=ERR_DATA. At the edge: s_valid←0, state←IDLE, timeout_flag←1.
  - timeout_flag is sticky and cleared only by reset.
  - If s_ready arrives in the same cycle as the timeout, s_ready wins: normal completion with s_rdata, flag unchanged.
- Undefined: no counter; BUSY waits indefinitely; timeout_flag is tied 0.

Test Plan:
- m0 write addr 0x10 wdata 0xA5, peripheral acks after 1 cycle → s_valid high cycle N+1 with s_addr=0x10/s_we=1; m0_ready pulse cycle N+2; m1_ready stays 0.
- m0 and m1 both read in the same IDLE cycle, held continuously → grants alternate: m0, m1, m0, m1; grant_id toggles; each master gets exactly one ready per transaction.
- m1 read 0x14 with s_rdata=0x3C → m1_ready pulse with m_rdata=0x3C; s_valid low the following cycle; no second peripheral ack.
- m1 raises valid while m0 is BUSY → m1 granted the cycle after m0 completes; m1 addr unchanged on s_addr until its own completion.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, peripheral never acks → m0_ready pulse after 4 BUSY cycles with m_rdata=0xDEADBEEF; timeout_flag=1 and stays 1; next transaction completes normally.
- resetn pulsed low during BUSY → s_valid, busy and mX_ready go 0 immediately; after release, both requesting → m0 granted first.
